ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register and operand-forwarding front end of the RV32I execute stage, directly upstream of the ALU. It captures decoded instructions from ID and resolves RAW hazards by forwarding from MEM and WB or by inserting a load-use bubble. It drives the ALU's `operand_a`, `operand_b` and `alu_op` inputs plus the side-band fields the MEM stage consumes.

## Interface
- No parameters; data width is fixed at 32, register address width at 5.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`  in  32  instruction PC
- `id_rs1_addr`, `id_rs2_addr`  in  5 each  source register indices
- `id_rs1_data`, `id_rs2_data`  in  32 each  register-file read data
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  instruction actually reads that source
- `id_imm`  in  32  sign-extended immediate
- `id_alu_op`  in  4  ALU opcode, ADD=0 … AUIPC=11, passed through
- `id_src_a_sel`  in  2  00=rs1, 01=pc, 10=zero, 11=zero
- `id_src_b_imm`  in  1  1=imm, 0=rs2
- `id_rd_addr`  in  5, `id_reg_write`  in  1, `id_is_load`  in  1
- `flush`  in  1  branch/jump redirect; kill the instruction entering EX
- `ex_hold`  in  1  downstream stall; freeze EX contents
- `mem_rd_addr`  in  5, `mem_reg_write`  in  1, `mem_result`  in  32  EX/MEM forward source
- `wb_rd_addr`  in  5, `wb_reg_write`  in  1, `wb_result`  in  32  MEM/WB forward source
- `ex_valid`  out  1
- `ex_operand_a`, `ex_operand_b`  out  32  to the ALU
- `ex_alu_op`  out  4  to the ALU
- `ex_store_data`  out  32  forwarded rs2 for stores
- `ex_rd_addr`  out  5, `ex_reg_write`  out  1, `ex_is_load`  out  1
- `stall_id`  out  1  hold PC/IF/ID this cycle

## Operation
- EX register fields: valid, pc, rs1/rs2 addr, rs1/rs2 data, imm, alu_op, src_a_sel, src_b_imm, rd, reg_write, is_load.
- Capture bypass: when ID is latched, if `wb_reg_write` is 1, `wb_rd_addr` is nonzero and equals `id_rsN_addr`, latch `wb_result` instead of `id_rsN_data`. This covers the same-cycle regfile write.
- Source index 0 always yields 0 and is never forwarded.
- Forwarding is combinational on the registered rs values, with priority MEM > WB > registered data. A source matches when `*_reg_write` is 1 and its rd is nonzero and equals the EX rs address.
- `ex_operand_a` selects forwarded rs1, pc, or 0 according to src_a_sel. `ex_operand_b` is imm when src_b_imm=1, otherwise forwarded rs2. `ex_store_data` is always forwarded rs2.
- Load-use hazard: `ex_valid` & `ex_is_load` & `ex_rd_addr`≠0 & `id_valid` & ((`id_uses_rs1` & rs1 match) | (`id_uses_rs2` & rs2 match)).
- `stall_id` = `ex_hold` | load-use hazard. It is 0 while `rst` is 1.
- Update priority on each edge: `rst` > `flush` > `ex_hold` > load-use > normal.
  - `rst` or `flush`: valid←0, all other fields←0.
  - `ex_hold`: all fields hold.
  - Load-use: valid←0 (bubble), reg_write←0, is_load←0; other fields don't care.
  - Normal: valid←`id_valid`, all fields←ID. reg_write and is_load are ANDed with `id_valid`.
- `flush` with `ex_hold` both high: flush wins.

## Timing
- Latency is 1 cycle from ID inputs to EX outputs. Forward paths are same-cycle combinational.
- Reset values: `ex_valid`, `ex_reg_write` and `ex_is_load` are 0. `ex_rd_addr` and `ex_alu_op` are 0. `ex_operand_a`, `ex_operand_b` and `ex_store_data` are 0.
- Load-use costs exactly one bubble. The load then sits in WB and is forwarded from `wb_result`.
- While `ex_hold` is 1, outputs stay stable apart from the forward muxes tracking MEM/WB.
- `rst` asserted mid-stream discards the EX content on that edge.

## Configuration
- `EX_FORWARD_EN` defined: MEM/WB forwarding active, with load-use stall only.
- `EX_FORWARD_EN` undefined: forward muxes are removed and registered data is used directly, with the capture bypass retained.
  - `stall_id` then also asserts for any used ID source matching a nonzero rd with reg_write in EX (`ex_valid`) or in MEM.
  - Each such stall inserts a bubble as in the load-use case.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs -> all outputs 0 and `stall_id`=0. The first valid ID instruction appears on EX outputs 1 cycle after `rst` falls.
- MEM vs WB priority: EX has rs1=x5; MEM writes x5=0x11111111 and WB writes x5=0x22222222 -> `ex_operand_a`=0x11111111. Repeat with `mem_reg_write`=0 -> 0x22222222.
- Load-use: EX holds `lw x7`, ID has `add x8,x7,x1` -> `stall_id`=1 for one cycle and `ex_valid`=0 next cycle. The add then enters EX with `wb_result`=0xDEADBEEF forwarded into `ex_operand_a`.
- x0 handling: WB writes rd=0 with 0xFFFFFFFF while ID/EX reads x0 -> operand 0, no forward, no stall.
- Flush and hold together: assert `flush` and `ex_hold` on the same edge -> `ex_valid`=0. Hold alone for 3 cycles -> EX fields unchanged and `stall_id`=1 for all 3.
- `EX_FORWARD_EN` undefined: back-to-back `addi x3,x0,5; add x4,x3,x3` -> stall until x3 leaves MEM. The add then executes with operand_a=operand_b=5 via the capture bypass or the regfile.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW-hazard resolution for the RV32I execute stage.
// Define EX_FORWARD_EN for MEM/WB operand forwarding; otherwise dependent instructions stall.
module ex_operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_alu_op,
    input  logic [1:0]  id_src_a_sel,
    input  logic        id_src_b_imm,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_reg_write,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd_addr,
    input  logic        wb_reg_write,
    input  logic [31:0] wb_result,
    output logic        ex_valid,
    output logic [31:0] ex_operand_a,
    output logic [31:0] ex_operand_b,
    output logic [3:0]  ex_alu_op,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_reg_write,
    output logic        ex_is_load,
    output logic        stall_id
);

    logic [31:0] pc_q;
    logic [4:0]  rs1_addr_q, rs2_addr_q;
    logic [31:0] rs1_data_q, rs2_data_q;
    logic [31:0] imm_q;
    logic [1:0]  src_a_sel_q;
    logic        src_b_imm_q;

    logic [31:0] cap_rs1, cap_rs2;
    logic [31:0] fwd_rs1, fwd_rs2;
    logic        rs1_hits_ex, rs2_hits_ex;
    logic        load_use, data_hazard;

    // x0 reads as zero; a same-cycle WB write beats the stale regfile read.
    always_comb begin
        cap_rs1 = id_rs1_data;
        cap_rs2 = id_rs2_data;
        if (wb_reg_write && (wb_rd_addr == id_rs1_addr)) cap_rs1 = wb_result;
        if (wb_reg_write && (wb_rd_addr == id_rs2_addr)) cap_rs2 = wb_result;
        if (id_rs1_addr == 5'd0) cap_rs1 = '0;
        if (id_rs2_addr == 5'd0) cap_rs2 = '0;
    end

    assign rs1_hits_ex = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    assign rs2_hits_ex = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
    assign load_use    = ex_valid && ex_is_load && (ex_rd_addr != 5'd0) && id_valid &&
                         (rs1_hits_ex || rs2_hits_ex);

`ifdef EX_FORWARD_EN
    assign data_hazard = load_use;

    always_comb begin
        fwd_rs1 = rs1_data_q;
        fwd_rs2 = rs2_data_q;
        if (rs1_addr_q != 5'd0) begin
            if (mem_reg_write && (mem_rd_addr == rs1_addr_q))     fwd_rs1 = mem_result;
            else if (wb_reg_write && (wb_rd_addr == rs1_addr_q))  fwd_rs1 = wb_result;
        end
        if (rs2_addr_q != 5'd0) begin
            if (mem_reg_write && (mem_rd_addr == rs2_addr_q))     fwd_rs2 = mem_result;
            else if (wb_reg_write && (wb_rd_addr == rs2_addr_q))  fwd_rs2 = wb_result;
        end
    end
`else
    logic ex_dep, mem_dep;
    logic unused_fwd;

    // Without forwarding, wait until the producer has reached WB (capture bypass covers it).
    assign ex_dep  = ex_valid && ex_reg_write && (ex_rd_addr != 5'd0) && (rs1_hits_ex || rs2_hits_ex);
    assign mem_dep = mem_reg_write && (mem_rd_addr != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1_addr == mem_rd_addr)) ||
                      (id_uses_rs2 && (id_rs2_addr == mem_rd_addr)));
    assign data_hazard = load_use || (id_valid && (ex_dep || mem_dep));

    assign fwd_rs1    = rs1_data_q;
    assign fwd_rs2    = rs2_data_q;
    assign unused_fwd = ^{mem_result, rs1_addr_q, rs2_addr_q};
`endif

    assign stall_id = !rst && (ex_hold || data_hazard);

    always_comb begin
        case (src_a_sel_q)
            2'b00:   ex_operand_a = fwd_rs1;
            2'b01:   ex_operand_a = pc_q;
            default: ex_operand_a = '0;
        endcase
    end

    assign ex_operand_b  = src_b_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid     <= 1'b0;
            pc_q         <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            ex_alu_op    <= '0;
            src_a_sel_q  <= '0;
            src_b_imm_q  <= 1'b0;
            ex_rd_addr   <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
        end else if (!ex_hold) begin
            // A bubble still latches the ID fields; only its control bits are killed.
            pc_q         <= id_pc;
            rs1_addr_q   <= id_rs1_addr;
            rs2_addr_q   <= id_rs2_addr;
            rs1_data_q   <= cap_rs1;
            rs2_data_q   <= cap_rs2;
            imm_q        <= id_imm;
            ex_alu_op    <= id_alu_op;
            src_a_sel_q  <= id_src_a_sel;
            src_b_imm_q  <= id_src_b_imm;
            ex_rd_addr   <= id_rd_addr;
            ex_valid     <= id_valid && !data_hazard;
            ex_reg_write <= id_valid && id_reg_write && !data_hazard;
            ex_is_load   <= id_valid && id_is_load && !data_hazard;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage; expectations follow EX_FORWARD_EN.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic        id_uses_rs1, id_uses_rs2;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_src_a_sel;
    logic        id_src_b_imm;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write, id_is_load;
    logic        flush, ex_hold;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_write;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] ex_operand_a, ex_operand_b, ex_store_data;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_is_load, stall_id;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_src_a_sel(id_src_a_sel), .id_src_b_imm(id_src_b_imm),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .flush(flush), .ex_hold(ex_hold),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
        .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .stall_id(stall_id)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        id_valid = 0; id_pc = '0; id_rs1_addr = '0; id_rs2_addr = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_imm = '0; id_alu_op = '0; id_src_a_sel = '0; id_src_b_imm = 0;
        id_rd_addr = '0; id_reg_write = 0; id_is_load = 0;
        flush = 0; ex_hold = 0;
        mem_rd_addr = '0; mem_reg_write = 0; mem_result = '0;
        wb_rd_addr = '0; wb_reg_write = 0; wb_result = '0;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic u1, input logic u2, input logic [31:0] imm,
                            input logic [3:0] op, input logic [1:0] asel, input logic bimm,
                            input logic [4:0] rd, input logic rw, input logic ld);
        id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_imm = imm; id_alu_op = op; id_src_a_sel = asel; id_src_b_imm = bimm;
        id_rd_addr = rd; id_reg_write = rw; id_is_load = ld;
    endtask

    task automatic flush_ex;
        idle_inputs();
        flush = 1;
        step();
        flush = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        for (int c = 0; c < 2; c++) begin
            id_valid = 1'($urandom); id_pc = $urandom; id_rs1_addr = 5'($urandom);
            id_rs2_addr = 5'($urandom); id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); id_imm = $urandom;
            id_alu_op = 4'($urandom); id_src_a_sel = 2'($urandom); id_src_b_imm = 1'($urandom);
            id_rd_addr = 5'($urandom); id_reg_write = 1'($urandom); id_is_load = 1'($urandom);
            flush = 1'($urandom); ex_hold = 1'($urandom);
            mem_rd_addr = 5'($urandom); mem_reg_write = 1'($urandom); mem_result = $urandom;
            wb_rd_addr = 5'($urandom); wb_reg_write = 1'($urandom); wb_result = $urandom;
            step();
            n_cmp++; if ({ex_valid, ex_reg_write, ex_is_load, ex_rd_addr, ex_alu_op} !== 12'h0) begin
                n_err++; $display("FAIL reset_ctrl: {valid,rw,ld,rd,op}=%h expected 000", {ex_valid, ex_reg_write, ex_is_load, ex_rd_addr, ex_alu_op}); end
            n_cmp++; if ({ex_operand_a, ex_operand_b, ex_store_data} !== 96'h0) begin
                n_err++; $display("FAIL reset_data: a=%h b=%h st=%h expected 0", ex_operand_a, ex_operand_b, ex_store_data); end
            n_cmp++; if (stall_id !== 1'b0) begin
                n_err++; $display("FAIL reset_stall: stall_id=%b expected 0", stall_id); end
        end
        idle_inputs();
        rst = 0;
        drive_id(32'h100, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h4, 4'd0, 2'b01, 1, 5'd1, 1, 0);
        step();
        n_cmp++; if ({ex_valid, ex_reg_write, ex_rd_addr} !== {1'b1, 1'b1, 5'd1}) begin
            n_err++; $display("FAIL first_instr_ctrl: {valid,rw,rd}=%b expected 1100001", {ex_valid, ex_reg_write, ex_rd_addr}); end
        n_cmp++; if ({ex_operand_a, ex_operand_b} !== {32'h100, 32'h4}) begin
            n_err++; $display("FAIL first_instr_ops: a=%h b=%h expected 00000100 00000004", ex_operand_a, ex_operand_b); end
    endtask

    task automatic test_priority;
        flush_ex();
        drive_id(32'h0, 5'd5, 5'd5, 32'h33333333, 32'h33333333, 1, 1, 32'h40, 4'd0, 2'b00, 1, 5'd9, 1, 0);
        step();
        idle_inputs();
        mem_rd_addr = 5'd5; mem_reg_write = 1; mem_result = 32'h11111111;
        wb_rd_addr = 5'd5; wb_reg_write = 1; wb_result = 32'h22222222;
        #1;
`ifdef EX_FORWARD_EN
        n_cmp++; if (ex_operand_a !== 32'h11111111) begin
            n_err++; $display("FAIL prio_mem_over_wb: a=%h expected 11111111", ex_operand_a); end
        n_cmp++; if ({ex_operand_b, ex_store_data} !== {32'h40, 32'h11111111}) begin
            n_err++; $display("FAIL prio_store: b=%h st=%h expected 00000040 11111111", ex_operand_b, ex_store_data); end
        mem_reg_write = 0;
        #1;
        n_cmp++; if (ex_operand_a !== 32'h22222222) begin
            n_err++; $display("FAIL prio_wb_only: a=%h expected 22222222", ex_operand_a); end
`else
        n_cmp++; if ({ex_operand_a, ex_store_data} !== {32'h33333333, 32'h33333333}) begin
            n_err++; $display("FAIL nofwd_registered: a=%h st=%h expected 33333333", ex_operand_a, ex_store_data); end
        mem_reg_write = 0;
        #1;
        n_cmp++; if (ex_operand_a !== 32'h33333333) begin
            n_err++; $display("FAIL nofwd_wb_ignored: a=%h expected 33333333", ex_operand_a); end
`endif
        wb_reg_write = 0;
        #1;
        n_cmp++; if (ex_operand_a !== 32'h33333333) begin
            n_err++; $display("FAIL prio_none: a=%h expected 33333333", ex_operand_a); end
    endtask

    task automatic test_capture_bypass;
        flush_ex();
        drive_id(32'h0, 5'd6, 5'd6, 32'hAAAA0000, 32'hAAAA0000, 1, 1, 32'h0, 4'd0, 2'b00, 0, 5'd12, 1, 0);
        wb_rd_addr = 5'd6; wb_reg_write = 1; wb_result = 32'h12345678;
        step();
        idle_inputs();
        #1;
        n_cmp++; if ({ex_operand_a, ex_operand_b} !== {32'h12345678, 32'h12345678}) begin
            n_err++; $display("FAIL capture_bypass: a=%h b=%h expected 12345678", ex_operand_a, ex_operand_b); end
    endtask

    task automatic test_load_use;
        flush_ex();
        drive_id(32'h0, 5'd2, 5'd0, 32'h1000, 32'h0, 1, 0, 32'h8, 4'd0, 2'b00, 1, 5'd7, 1, 1);
        step();
        drive_id(32'h4, 5'd7, 5'd1, 32'h0, 32'h5, 1, 1, 32'h0, 4'd0, 2'b00, 0, 5'd8, 1, 0);
        #1;
        n_cmp++; if (stall_id !== 1'b1) begin
            n_err++; $display("FAIL load_use_stall: stall_id=%b expected 1", stall_id); end
        step();
        mem_rd_addr = 5'd7; mem_reg_write = 1; mem_result = 32'h00001008;
        #1;
        n_cmp++; if ({ex_valid, ex_reg_write, ex_is_load} !== 3'b000) begin
            n_err++; $display("FAIL load_use_bubble: {valid,rw,ld}=%b expected 000", {ex_valid, ex_reg_write, ex_is_load}); end
`ifdef EX_FORWARD_EN
        n_cmp++; if (stall_id !== 1'b0) begin
            n_err++; $display("FAIL load_use_one_bubble: stall_id=%b expected 0", stall_id); end
        step();
        mem_reg_write = 0;
        wb_rd_addr = 5'd7; wb_reg_write = 1; wb_result = 32'hDEADBEEF;
`else
        n_cmp++; if (stall_id !== 1'b1) begin
            n_err++; $display("FAIL nofwd_mem_stall: stall_id=%b expected 1", stall_id); end
        step();
        mem_reg_write = 0;
        wb_rd_addr = 5'd7; wb_reg_write = 1; wb_result = 32'hDEADBEEF;
        #1;
        n_cmp++; if ({ex_valid, stall_id} !== 2'b00) begin
            n_err++; $display("FAIL nofwd_release: {valid,stall}=%b expected 00", {ex_valid, stall_id}); end
        step();
        wb_reg_write = 0;
`endif
        #1;
        n_cmp++; if ({ex_valid, ex_rd_addr} !== {1'b1, 5'd8}) begin
            n_err++; $display("FAIL load_use_add_valid: {valid,rd}=%b expected 101000", {ex_valid, ex_rd_addr}); end
        n_cmp++; if ({ex_operand_a, ex_operand_b} !== {32'hDEADBEEF, 32'h5}) begin
            n_err++; $display("FAIL load_use_fwd: a=%h b=%h expected deadbeef 00000005", ex_operand_a, ex_operand_b); end
    endtask

    task automatic test_x0;
        flush_ex();
        drive_id(32'h0, 5'd2, 5'd0, 32'h0, 32'h0, 1, 0, 32'h0, 4'd0, 2'b00, 1, 5'd0, 1, 1);
        step();
        drive_id(32'h4, 5'd0, 5'd0, 32'h0, 32'h0, 1, 1, 32'h0, 4'd0, 2'b00, 0, 5'd3, 1, 0);
        wb_rd_addr = 5'd0; wb_reg_write = 1; wb_result = 32'hFFFFFFFF;
        mem_rd_addr = 5'd0; mem_reg_write = 1; mem_result = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (stall_id !== 1'b0) begin
            n_err++; $display("FAIL x0_no_stall: stall_id=%b expected 0", stall_id); end
        step();
        n_cmp++; if ({ex_valid, ex_operand_a, ex_operand_b} !== {1'b1, 32'h0, 32'h0}) begin
            n_err++; $display("FAIL x0_operands: valid=%b a=%h b=%h expected 1 0 0", ex_valid, ex_operand_a, ex_operand_b); end
        idle_inputs();
    endtask

    task automatic test_flush_hold;
        flush_ex();
        drive_id(32'h200, 5'd10, 5'd0, 32'h77, 32'h0, 1, 0, 32'h10, 4'd3, 2'b00, 1, 5'd11, 1, 0);
        step();
        drive_id(32'h300, 5'd12, 5'd13, 32'h99, 32'h98, 1, 1, 32'h20, 4'd5, 2'b00, 0, 5'd14, 1, 0);
        flush = 1; ex_hold = 1;
        step();
        flush = 0; ex_hold = 0;
        n_cmp++; if ({ex_valid, ex_reg_write, ex_operand_a} !== {1'b0, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL flush_over_hold: valid=%b rw=%b a=%h expected 0 0 0", ex_valid, ex_reg_write, ex_operand_a); end
        drive_id(32'h200, 5'd10, 5'd0, 32'h77, 32'h0, 1, 0, 32'h10, 4'd3, 2'b00, 1, 5'd11, 1, 0);
        step();
        drive_id(32'h300, 5'd12, 5'd13, 32'h99, 32'h98, 1, 1, 32'h20, 4'd5, 2'b00, 0, 5'd14, 1, 0);
        ex_hold = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (stall_id !== 1'b1) begin
                n_err++; $display("FAIL hold_stall[%0d]: stall_id=%b expected 1", c, stall_id); end
            step();
            n_cmp++; if ({ex_valid, ex_operand_a, ex_operand_b, ex_alu_op, ex_rd_addr} !==
                         {1'b1, 32'h77, 32'h10, 4'd3, 5'd11}) begin
                n_err++; $display("FAIL hold_fields[%0d]: valid=%b a=%h b=%h op=%0d rd=%0d expected 1 77 10 3 11",
                                  c, ex_valid, ex_operand_a, ex_operand_b, ex_alu_op, ex_rd_addr); end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        flush_ex();
        drive_id(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1, 0, 32'h5, 4'd0, 2'b00, 1, 5'd3, 1, 0);
        step();
        drive_id(32'h4, 5'd3, 5'd3, 32'h0, 32'h0, 1, 1, 32'h0, 4'd0, 2'b00, 0, 5'd4, 1, 0);
        #1;
`ifdef EX_FORWARD_EN
        n_cmp++; if (stall_id !== 1'b0) begin
            n_err++; $display("FAIL b2b_no_stall: stall_id=%b expected 0", stall_id); end
        step();
        mem_rd_addr = 5'd3; mem_reg_write = 1; mem_result = 32'h5;
`else
        n_cmp++; if (stall_id !== 1'b1) begin
            n_err++; $display("FAIL b2b_stall_ex: stall_id=%b expected 1", stall_id); end
        step();
        mem_rd_addr = 5'd3; mem_reg_write = 1; mem_result = 32'h5;
        #1;
        n_cmp++; if ({ex_valid, stall_id} !== 2'b01) begin
            n_err++; $display("FAIL b2b_stall_mem: {valid,stall}=%b expected 01", {ex_valid, stall_id}); end
        step();
        mem_reg_write = 0;
        wb_rd_addr = 5'd3; wb_reg_write = 1; wb_result = 32'h5;
        #1;
        n_cmp++; if ({ex_valid, stall_id} !== 2'b00) begin
            n_err++; $display("FAIL b2b_release: {valid,stall}=%b expected 00", {ex_valid, stall_id}); end
        step();
        wb_reg_write = 0;
`endif
        #1;
        n_cmp++; if ({ex_valid, ex_operand_a, ex_operand_b} !== {1'b1, 32'h5, 32'h5}) begin
            n_err++; $display("FAIL b2b_add: valid=%b a=%h b=%h expected 1 5 5", ex_valid, ex_operand_a, ex_operand_b); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_priority();
        test_capture_bypass();
        test_load_use();
        test_x0();
        test_flush_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
